serial_tx_arbiter: RTL and testbench

//  Shares the single UART serial transmitter between NREQ byte producers (PicoBlaze

---
 rtl/serial_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers, one byte per grant.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
//
// state     | meaning
// IDLE      | offering req_ready to the arbitration winner while the transmitter is free
// START     | tx_start pulse for the byte just accepted
// WAIT_BUSY | waiting for tx_busy to rise; the watchdog runs here
// WAIT_DONE | transmitter shifting the frame; waiting for tx_busy to fall

module serial_tx_arbiter #(
   parameter int DATA_W  = 8,
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*DATA_W-1:0] req_data,
   output logic [NREQ-1:0]        req_ready,
   output logic [DATA_W-1:0]      tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   output logic [1:0]             grant_id,
   input  logic                   err_clr,
   output logic                   err_timeout
);

   localparam int TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

   state_t            state;
   logic [TW-1:0]     timer;
   logic [TW-1:0]     timer_inc;
   logic [1:0]        base;
   logic [NREQ-1:0]   rot;
   logic [1:0]        off;
   logic [2:0]        sum;
   logic [1:0]        winner;
   logic              found;
   logic [DATA_W-1:0] sel_data;
   logic              transfer;

`ifdef ARB_FIXED_PRIO_EN
   assign base = 2'd0;
`else
   logic [1:0] rr_ptr;
   logic [2:0] ptr_next;

   assign base = rr_ptr;

   always_comb begin
      ptr_next = {1'b0, winner} + 3'd1;
      if (ptr_next == 3'(NREQ))
         ptr_next = 3'd0;
   end
`endif

   // Rotate the requests so the search always starts at bit 0, then map back.
   always_comb begin
      rot   = NREQ'({req_valid, req_valid} >> base);
      found = 1'b0;
      off   = 2'd0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (rot[j]) begin
            found = 1'b1;
            off   = 2'(j);
         end
      end
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= 3'(NREQ))
         sum = sum - 3'(NREQ);
      winner = sum[1:0];
   end

   always_comb begin
      sel_data = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (winner == 2'(j))
            sel_data = req_data[j*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      req_ready = '0;
      if (!reset && state == IDLE && !tx_busy && found)
         req_ready = NREQ'(1) << winner;
   end

   assign transfer  = |(req_valid & req_ready);
   assign timer_inc = timer + TW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         tx_data     <= '0;
         tx_start    <= 1'b0;
         grant_id    <= 2'd0;
         err_timeout <= 1'b0;
         timer       <= '0;
`ifndef ARB_FIXED_PRIO_EN
         rr_ptr      <= 2'd0;
`endif
      end else begin
         tx_start <= 1'b0;
         if (err_clr)
            err_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (transfer) begin
                  tx_data  <= sel_data;
                  grant_id <= winner;
                  tx_start <= 1'b1;
`ifndef ARB_FIXED_PRIO_EN
                  rr_ptr   <= ptr_next[1:0];
`endif
                  state    <= START;
               end
            end
            START: begin
               timer <= '0;
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end else begin
                  timer <= timer_inc;
                  // set after the clear above so a simultaneous err_clr loses
                  if (timer_inc == TW'(TIMEOUT - 1)) begin
                     err_timeout <= 1'b1;
                     state       <= IDLE;
                  end
               end
            end
            WAIT_DONE: begin
               if (!tx_busy)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: directed requests, a simple UART TX busy model,
// and a monitor that checks every tx_start against the queued expected byte and grant.

module tb_serial_tx_arbiter;

   localparam int DATA_W  = 8;
   localparam int NREQ    = 2;
   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic [NREQ-1:0]        req_valid = '0;
   logic [NREQ*DATA_W-1:0] req_data = '0;
   logic [NREQ-1:0]        req_ready;
   logic [DATA_W-1:0]      tx_data;
   logic                   tx_start;
   logic                   tx_busy;
   logic [1:0]             grant_id;
   logic                   err_clr = 1'b0;
   logic                   err_timeout;

   logic model_busy = 1'b0;
   logic busy_force = 1'b0;
   logic never_busy = 1'b0;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t sbq[$];
   exp_t mon_e;

   assign tx_busy = model_busy | busy_force;

   serial_tx_arbiter #(.DATA_W(DATA_W), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .grant_id(grant_id), .err_clr(err_clr), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_tx(input logic [1:0] id, input logic [7:0] d);
      exp_t e;
      e.id   = id;
      e.data = d;
      sbq.push_back(e);
   endtask

   // Transmitter model: busy rises 3 cycles after the start pulse and stays high for 10.
   always begin
      @(negedge clk);
      if (tx_start && !never_busy) begin
         repeat (2) @(negedge clk);
         model_busy = 1'b1;
         repeat (10) @(negedge clk);
         model_busy = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (tx_start === 1'b1) begin
         if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_start: got grant %0d data %0h, expected no start", grant_id, tx_data);
         end else begin
            mon_e = sbq.pop_front();
            check("tx_grant", 32'(grant_id), 32'(mon_e.id));
            check("tx_data", 32'(tx_data), 32'(mon_e.data));
         end
      end
   end

   // Ends at the negedge right after the accepting edge.
   task automatic wait_ready(input logic [NREQ-1:0] mask, input string name);
      int n;
      n = 0;
      #1;
      while ((req_ready & mask) == '0 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(name, 32'(req_ready), 32'(mask));
      @(negedge clk);
   endtask

   task automatic finish_byte(input string name);
      int n;
      n = 0;
      #1;
      while (tx_busy !== 1'b1 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({name, "_busy_rise"}, 32'(tx_busy), 32'd1);
      n = 0;
      while (tx_busy !== 1'b0 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({name, "_busy_fall"}, 32'(tx_busy), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      miscompares++;
      $display("FAIL global_timeout: got no end of test, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      int         k;
      int         early;
      logic       seen;
      logic [1:0] ids[4];

      // Reset and idle outputs
      #20;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_start", 32'(tx_start), 32'd0);
      #30 reset = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      check("idle_ready", 32'(req_ready), 32'd0);
      check("idle_tx_data", 32'(tx_data), 32'd0);
      check("idle_grant", 32'(grant_id), 32'd0);
      check("idle_err", 32'(err_timeout), 32'd0);
      check("idle_start", 32'(tx_start), 32'd0);
      @(negedge clk);

      // Single byte from requester 0, second byte only after busy falls
      req_valid = 2'b01;
      req_data  = {8'h00, 8'h41};
      expect_tx(2'd0, 8'h41);
      #1 check("t2_ready", 32'(req_ready), 32'b01);
      @(negedge clk);
      #1;
      check("t2_ready_one_cycle", 32'(req_ready), 32'd0);
      check("t2_start", 32'(tx_start), 32'd1);
      req_data = {8'h00, 8'h42};
      seen  = 1'b0;
      early = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         #1;
         if (tx_busy) seen = 1'b1;
         if (seen && !tx_busy) break;
         if (req_ready != '0) early++;
      end
      check("t2_no_early_ready", 32'(early), 32'd0);
      check("t2_ready_at_fall", 32'(req_ready), 32'd0);
      expect_tx(2'd0, 8'h42);
      @(negedge clk);
      #1 check("t2_accept_after_fall", 32'(req_ready), 32'b01);
      @(negedge clk);
      req_valid = '0;
      finish_byte("t2");

      // Request while transmitter busy in IDLE
      busy_force = 1'b1;
      req_valid  = 2'b10;
      req_data   = {8'h33, 8'h00};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 check("t6_ready_while_busy", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      busy_force = 1'b0;
      expect_tx(2'd1, 8'h33);
      #1 check("t6_ready_after_busy", 32'(req_ready), 32'b10);
      @(negedge clk);
      req_valid = '0;
      finish_byte("t6");

      // Both requesters held valid for four bytes
`ifdef ARB_FIXED_PRIO_EN
      ids = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
      ids = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
      req_valid = 2'b11;
      req_data  = {8'h22, 8'h11};
      for (int i = 0; i < 4; i++) begin
         expect_tx(ids[i], (ids[i] == 2'd0) ? 8'h11 : 8'h22);
         wait_ready(2'b01 << ids[i], "t3_grant_ready");
         if (i == 3) req_valid = '0;
         finish_byte("t3");
      end

      // Transmitter never answers: watchdog
      never_busy = 1'b1;
      req_valid  = 2'b01;
      req_data   = {8'h00, 8'h55};
      expect_tx(2'd0, 8'h55);
      wait_ready(2'b01, "t4_ready");
      req_valid = '0;
      k = 0;
      while (err_timeout !== 1'b1 && k < 40) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("t4_timeout_latency", 32'(k), 32'(TIMEOUT));
      never_busy = 1'b0;
      req_valid  = 2'b10;
      req_data   = {8'h66, 8'h00};
      expect_tx(2'd1, 8'h66);
      wait_ready(2'b10, "t4_next_ready");
      req_valid = '0;
      check("t4_err_sticky", 32'(err_timeout), 32'd1);
      finish_byte("t4");
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      #1 check("t4_err_clr", 32'(err_timeout), 32'd0);
      @(negedge clk);

      // Reset during WAIT_DONE, then pointer back at 0
      req_valid = 2'b01;
      req_data  = {8'h00, 8'h99};
      expect_tx(2'd0, 8'h99);
      wait_ready(2'b01, "t5_ready");
      req_valid = '0;
      k = 0;
      while (tx_busy !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t5_rst_tx_data", 32'(tx_data), 32'd0);
      check("t5_rst_grant", 32'(grant_id), 32'd0);
      check("t5_rst_start", 32'(tx_start), 32'd0);
      check("t5_rst_ready", 32'(req_ready), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      k = 0;
      while (tx_busy !== 1'b0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      req_valid = 2'b11;
      req_data  = {8'hAA, 8'hBB};
      expect_tx(2'd0, 8'hBB);
      wait_ready(2'b01, "t5_ready_after_reset");
      req_valid = '0;
      finish_byte("t5");

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
